buffer_arb: RTL and testbench

Two-requester round-robin arbiter with an internal FIFO that shares the 32-bit `buffer` datapath between two producers. Each producer offers words through a valid/ready handshake. The arbiter grants at most one producer per cycle, stores the granted word in a DEPTH-entry FIFO, and presents the FIFO head to a single consumer through a valid/ready handshake. The block sits in front of the buffer and replaces the raw `in0`/`in1`/`in_en` drive with fair, flow-controlled sequencing.

---
 rtl/buffer_arb.sv | 115 +++++++++++
 tb/tb_buffer_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_arb.sv
// buffer_arb: two-requester round-robin arbiter feeding a DEPTH-entry FIFO
// that drives a single valid/ready consumer.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in0/in0_valid/in0_ready  requester 0 word, offer, grant (combinational)
//   in1/in1_valid/in1_ready  requester 1 word, offer, grant (combinational)
//   out/out_valid/out_ready  FIFO head word, non-empty flag, consumer accept
//   count                occupancy 0..DEPTH
//   last_grant           index of the most recently accepted requester
//   full, empty          occupancy flags
module buffer_arb #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             in0,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [N-1:0]             in1,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  output logic [N-1:0]             out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     last_grant,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_grant_q, last_grant_d;
  logic          grant0, grant1;
  logic          push, pop;

  // Occupancy flags and head presentation (no bypass path)
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == CW'(0));
  assign out_valid  = ~empty;
  assign out        = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign last_grant = last_grant_q;

  // Round-robin grant; reset forces both readies low even with valids high
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !full) begin
      if (in0_valid && in1_valid) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else if (in0_valid) begin
        grant0 = 1'b1;
      end else if (in1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign in0_ready = grant0;
  assign in1_ready = grant1;
  assign push      = grant0 | grant1;
  assign pop       = out_valid & out_ready;

  // Pointer, occupancy and priority next-state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + AW'(1);
      last_grant_d = grant1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Storage is not reset; only written on a grant
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= grant1 ? in1 : in0;
    end
  end

endmodule

// File: tb/tb_buffer_arb.sv
// Self-checking bench for buffer_arb: directed table, hand sequences for the
// full/wrap/reset corners, and randomized traffic against a queue model.
module tb_buffer_arb;

  logic        clk;
  logic        rst;
  logic [31:0] in0, in1;
  logic        in0_valid, in1_valid;
  logic        in0_ready, in1_ready;
  logic [31:0] out;
  logic        out_valid, out_ready;
  logic [2:0]  count;
  logic        last_grant, full, empty;

  buffer_arb #(.N(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1(in1), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .last_grant(last_grant), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ordered list of queued words plus priority bit
  logic [31:0] mq[$];
  logic        mlg;

  typedef struct packed {
    logic        r0, r1, ov;
    logic [31:0] dout;
    logic [2:0]  cnt;
    logic        lg, fl, em;
  } obs_t;

  typedef struct {
    logic        v0, v1;
    logic [31:0] d0, d1;
    logic        ordy;
    logic        er0, er1, eov;
    logic [31:0] eout;
    logic [2:0]  ecnt;
    logic        elg;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+1, check all outputs vs model at negedge,
  // advance model at the posedge.
  task automatic step(input logic v0, input logic v1, input logic [31:0] a0,
                      input logic [31:0] a1, input logic ordy, output obs_t o);
    logic g0, g1, efull;
    int   sz;
    in0_valid = v0; in1_valid = v1; in0 = a0; in1 = a1; out_ready = ordy;
    @(negedge clk);
    sz    = mq.size();
    efull = (sz == 4);
    g0 = 1'b0; g1 = 1'b0;
    if (!efull) begin
      if (v0 && v1) begin
        if (mlg) g0 = 1'b1; else g1 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
    end
    chk("in0_ready", {31'b0, in0_ready}, {31'b0, g0});
    chk("in1_ready", {31'b0, in1_ready}, {31'b0, g1});
    chk("out_valid", {31'b0, out_valid}, {31'b0, sz != 0});
    chk("count", {29'b0, count}, 32'(sz));
    chk("full", {31'b0, full}, {31'b0, efull});
    chk("empty", {31'b0, empty}, {31'b0, sz == 0});
    chk("last_grant", {31'b0, last_grant}, {31'b0, mlg});
    if (sz != 0) chk("out", out, mq[0]);
    o.r0 = in0_ready; o.r1 = in1_ready; o.ov = out_valid; o.dout = out;
    o.cnt = count; o.lg = last_grant; o.fl = full; o.em = empty;
    @(posedge clk);
    if (sz != 0 && ordy) void'(mq.pop_front());
    if (g0) begin mq.push_back(a0); mlg = 1'b0; end
    else if (g1) begin mq.push_back(a1); mlg = 1'b1; end
    #1;
  endtask

  vec_t vt[9];
  obs_t o;

  initial begin
    int pushes;
    int n0, n1;
    logic p0, p1, rv0, rv1, rordy;
    logic [31:0] rd0, rd1;

    vt[0] = '{1'b1, 1'b1, 32'h11, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 1'b1};
    vt[1] = '{1'b1, 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 3'd1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h11, 32'h22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 3'd1, 1'b1};
    vt[3] = '{1'b1, 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 3'd1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 32'h00, 32'h01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 3'd1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 32'h00, 32'h02, 1'b1, 1'b0, 1'b1, 1'b1, 32'h01, 3'd1, 1'b1};
    vt[6] = '{1'b0, 1'b1, 32'h00, 32'h03, 1'b1, 1'b0, 1'b1, 1'b1, 32'h02, 3'd1, 1'b1};
    vt[7] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h03, 3'd1, 1'b1};
    vt[8] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0, 1'b1};

    // Reset with both valids high
    mlg = 1'b1;
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    in0 = 32'h11; in1 = 32'h22; out_ready = 1'b0;
    #2;
    chk("rst_in0_ready", {31'b0, in0_ready}, 32'd0);
    chk("rst_in1_ready", {31'b0, in1_ready}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_last_grant", {31'b0, last_grant}, 32'd1);
    #7;
    in0_valid = 1'b0; in1_valid = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: first grant, alternation, single requester, idle
    for (int i = 0; i < 9; i++) begin
      step(vt[i].v0, vt[i].v1, vt[i].d0, vt[i].d1, vt[i].ordy, o);
      chk($sformatf("vec%0d_r0", i), {31'b0, o.r0}, {31'b0, vt[i].er0});
      chk($sformatf("vec%0d_r1", i), {31'b0, o.r1}, {31'b0, vt[i].er1});
      chk($sformatf("vec%0d_ov", i), {31'b0, o.ov}, {31'b0, vt[i].eov});
      chk($sformatf("vec%0d_cnt", i), {29'b0, o.cnt}, {29'b0, vt[i].ecnt});
      chk($sformatf("vec%0d_lg", i), {31'b0, o.lg}, {31'b0, vt[i].elg});
      if (vt[i].eov) chk($sformatf("vec%0d_out", i), o.dout, vt[i].eout);
    end

    // Fill to full with consumer stalled
    pushes = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 32'hA0, 32'hB0, 1'b0, o);
      pushes += int'(o.r0) + int'(o.r1);
    end
    chk("full_pushes", 32'(pushes), 32'd4);
    chk("full_flag", {31'b0, o.fl}, 32'd1);
    chk("full_r0", {31'b0, o.r0}, 32'd0);
    chk("full_r1", {31'b0, o.r1}, 32'd0);
    chk("full_head", o.dout, 32'hA0);
    // Pop while full: no same-cycle grant, next cycle grants requester 0
    step(1'b1, 1'b1, 32'hA0, 32'hB0, 1'b1, o);
    chk("popfull_r0", {31'b0, o.r0}, 32'd0);
    chk("popfull_r1", {31'b0, o.r1}, 32'd0);
    step(1'b1, 1'b1, 32'hA0, 32'hB0, 1'b0, o);
    chk("after_pop_r0", {31'b0, o.r0}, 32'd1);
    chk("after_pop_cnt", {29'b0, o.cnt}, 32'd3);

    // Drain to count 2, then 8 cycles of simultaneous push and pop
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, o);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, o);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 32'h100 + 32'(n0), 32'h200 + 32'(n1), 1'b1, o);
      chk($sformatf("wrap%0d_cnt", i), {29'b0, o.cnt}, 32'd2);
      if (o.r0) n0++;
      if (o.r1) n1++;
    end

    // Reach count 3, then reset mid-operation
    step(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, o);
    chk("pre_rst_count", {29'b0, count}, 32'd3);
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_count", {29'b0, count}, 32'd0);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_r0", {31'b0, in0_ready}, 32'd0);
    chk("mid_rst_r1", {31'b0, in1_ready}, 32'd0);
    chk("mid_rst_lg", {31'b0, last_grant}, 32'd1);
    mq.delete();
    mlg = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 32'h55, 32'h0, 1'b0, o);
    chk("post_rst_r0", {31'b0, o.r0}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, o);
    chk("post_rst_out", o.dout, 32'h55);
    chk("post_rst_cnt", {29'b0, o.cnt}, 32'd1);

    // Randomized traffic; requesters hold word and valid until granted
    p0 = 1'b0; p1 = 1'b0; rd0 = '0; rd1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0) begin p0 = 1'($urandom_range(0, 1)); rd0 = $urandom; end
      if (!p1) begin p1 = 1'($urandom_range(0, 1)); rd1 = $urandom; end
      rv0 = p0; rv1 = p1;
      if ((i % 80) < 20) rordy = 1'($urandom_range(0, 3) == 0);
      else               rordy = 1'($urandom_range(0, 3) != 0);
      step(rv0, rv1, rd0, rd1, rordy, o);
      if (o.r0) p0 = 1'b0;
      if (o.r1) p1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
